id_ex_hazard_stage: RTL and testbench

//  ID/EX pipeline register of the 5-stage MIPS pipeline, with load-use hazard detection.

---
 rtl/id_ex_hazard_stage.sv | 78 +++++++
 tb/tb_id_ex_hazard_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush bubble
// insertion, front-end freeze and a saturating count of hazard bubbles.
module id_ex_hazard_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [8:0]    ctrl_in,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic [AW-1:0] id_pc1,
  input  logic          flush,
  input  logic          hold,
  output logic [8:0]    ex_ctrl,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [AW-1:0] ex_pc1,
  output logic          pc_write,
  output logic          ifid_write,
  output logic [CW-1:0] stall_cnt
);

  localparam int unsigned CTRL_W = 9;

  logic uses_rt_c;
  logic hazard_c;
  logic freeze_c;

  // ID reads rt for R-type, stores/out and branches
  assign uses_rt_c = ctrl_in[3] | ctrl_in[4] | ctrl_in[6];

  // Load in EX whose destination (rt) is read by the instruction in ID
  assign hazard_c = ex_ctrl[5] && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (uses_rt_c && (ex_rt == id_rt)));

  // A taken branch kills ID anyway, so a hazard against it needs no freeze
  assign freeze_c   = hold | (hazard_c & ~flush);
  assign pc_write   = ~freeze_c;
  assign ifid_write = ~freeze_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl   <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_pc1    <= '0;
      stall_cnt <= '0;
    end else if (!hold || flush) begin
      // flush and hazard both turn the control word into a bubble
      ex_ctrl <= (flush || hazard_c) ? CTRL_W'(0) : ctrl_in;
      ex_rd1  <= id_rd1;
      ex_rd2  <= id_rd2;
      ex_imm  <= id_imm;
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
      ex_rd   <= id_rd;
      ex_pc1  <= id_pc1;
      if (!flush && hazard_c && (stall_cnt != {CW{1'b1}})) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: directed vector table plus randomized traffic
// checked against a behavioural pipeline model; a CW=2 copy checks saturation.
module tb_id_ex_hazard_stage;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW2 = 2;

  localparam logic [8:0] LDS = 9'h1A4;
  localparam logic [8:0] ADD = 9'h08B;
  localparam logic [8:0] ADI = 9'h084;
  localparam logic [8:0] STW = 9'h014;
  localparam logic [8:0] NML = 9'h184;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, hold;
  logic [8:0]    ctrl_in;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rd1, id_rd2, id_imm;
  logic [AW-1:0] id_pc1;

  logic [8:0]    ex_ctrl, ex_ctrl2;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_rd1_2, ex_rd2_2, ex_imm2;
  logic [4:0]    ex_rs, ex_rt, ex_rd, ex_rs2, ex_rt2, ex_rd2_s;
  logic [AW-1:0] ex_pc1, ex_pc1_2;
  logic          pc_write, ifid_write, pc_write2, ifid_write2;
  logic [CW-1:0] stall_cnt;
  logic [CW2-1:0] stall_cnt2;

  id_ex_hazard_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc1(id_pc1),
    .flush(flush), .hold(hold), .ex_ctrl(ex_ctrl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_pc1(ex_pc1),
    .pc_write(pc_write), .ifid_write(ifid_write), .stall_cnt(stall_cnt)
  );

  id_ex_hazard_stage #(.DW(DW), .AW(AW), .CW(CW2)) dut_sat (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc1(id_pc1),
    .flush(flush), .hold(hold), .ex_ctrl(ex_ctrl2), .ex_rd1(ex_rd1_2), .ex_rd2(ex_rd2_2),
    .ex_imm(ex_imm2), .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_rd(ex_rd2_s), .ex_pc1(ex_pc1_2),
    .pc_write(pc_write2), .ifid_write(ifid_write2), .stall_cnt(stall_cnt2)
  );

  typedef struct packed {
    logic rst, flush, hold;
    logic [8:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic [15:0] rd1, rd2, imm, pc1;
  } in_t;

  typedef struct packed {
    logic [8:0] ctrl;
    logic [15:0] rd1, rd2, imm, pc1;
    logic [4:0] rs, rt, rd;
  } ex_t;

  typedef struct packed {
    logic rst, flush, hold;
    logic [8:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic pcw;
    logic [8:0] ex_ctrl;
    logic [15:0] cnt;
    logic [1:0] cnt2;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  ex_t m;
  int  m_cnt, m_cnt2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The instruction in ID consumes the load result sitting in EX
  function automatic bit load_use(input ex_t e, input in_t v);
    bit reads_rt;
    reads_rt = v.ctrl[3] || v.ctrl[4] || v.ctrl[6];
    if (!e.ctrl[5] || e.rt == 5'd0) return 1'b0;
    return (e.rt == v.rs) || (reads_rt && e.rt == v.rt);
  endfunction

  function automatic ex_t from_id(input in_t v);
    ex_t e;
    e.ctrl = v.ctrl; e.rd1 = v.rd1; e.rd2 = v.rd2; e.imm = v.imm; e.pc1 = v.pc1;
    e.rs = v.rs; e.rt = v.rt; e.rd = v.rd;
    return e;
  endfunction

  function automatic in_t rnd_data(input in_t v);
    in_t r;
    r = v;
    r.rd1 = 16'($urandom()); r.rd2 = 16'($urandom());
    r.imm = 16'($urandom()); r.pc1 = 16'($urandom());
    return r;
  endfunction

  task automatic cycle(input in_t v, output logic pcw_mid);
    ex_t nx;
    bit  hz;
    bit  exp_pcw;
    rst = v.rst; flush = v.flush; hold = v.hold; ctrl_in = v.ctrl;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm = v.imm; id_pc1 = v.pc1;
    #4;
    hz = load_use(m, v);
    exp_pcw = !(v.hold || (hz && !v.flush));
    pcw_mid = pc_write;
    chk("pc_write", 64'(pc_write), 64'(exp_pcw));
    chk("ifid_write", 64'(ifid_write), 64'(exp_pcw));
    nx = m;
    if (v.rst) begin
      nx = '0; m_cnt = 0; m_cnt2 = 0;
    end else if (v.flush) begin
      nx = from_id(v); nx.ctrl = '0;
    end else if (!v.hold) begin
      nx = from_id(v);
      if (hz) begin
        nx.ctrl = '0;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
    m = nx;
    chk("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
    chk("ex_rd1", 64'(ex_rd1), 64'(m.rd1));
    chk("ex_rd2", 64'(ex_rd2), 64'(m.rd2));
    chk("ex_imm", 64'(ex_imm), 64'(m.imm));
    chk("ex_pc1", 64'(ex_pc1), 64'(m.pc1));
    chk("ex_rs", 64'(ex_rs), 64'(m.rs));
    chk("ex_rt", 64'(ex_rt), 64'(m.rt));
    chk("ex_rd", 64'(ex_rd), 64'(m.rd));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("stall_cnt_sat", 64'(stall_cnt2), 64'(m_cnt2));
  endtask

  function automatic vec_t mk(input logic r, f, h, input logic [8:0] c,
                              input logic [4:0] rs, rt, rd, input logic pcw,
                              input logic [8:0] ec, input logic [15:0] cnt,
                              input logic [1:0] cnt2);
    vec_t t;
    t.rst = r; t.flush = f; t.hold = h; t.ctrl = c; t.rs = rs; t.rt = rt; t.rd = rd;
    t.pcw = pcw; t.ex_ctrl = ec; t.cnt = cnt; t.cnt2 = cnt2;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    in_t  v;
    logic pcw_mid;

    //      rst flush hold ctrl   rs  rt  rd  pcw  ex_ctrl cnt cnt2
    tbl.push_back(mk(0, 0, 0, LDS,  1,  3,  0, 1, LDS,  0, 0));
    tbl.push_back(mk(0, 0, 0, ADD,  3,  4,  5, 0, 9'h0, 1, 1));
    tbl.push_back(mk(0, 0, 0, ADD,  3,  4,  5, 1, ADD,  1, 1));
    tbl.push_back(mk(0, 0, 0, LDS,  2,  0,  0, 1, LDS,  1, 1));
    tbl.push_back(mk(0, 0, 0, ADD,  0,  0,  5, 1, ADD,  1, 1));
    tbl.push_back(mk(0, 0, 0, LDS,  1,  6,  0, 1, LDS,  1, 1));
    tbl.push_back(mk(0, 1, 0, ADD,  6,  4,  5, 1, 9'h0, 1, 1));
    tbl.push_back(mk(0, 0, 0, LDS,  1,  7,  0, 1, LDS,  1, 1));
    tbl.push_back(mk(0, 0, 1, ADD,  7,  4,  5, 0, LDS,  1, 1));
    tbl.push_back(mk(0, 0, 1, 9'h0C4, 9, 2, 3, 0, LDS,  1, 1));
    tbl.push_back(mk(0, 0, 1, 9'h010, 5, 6, 1, 0, LDS,  1, 1));
    tbl.push_back(mk(0, 0, 0, ADD,  2,  7,  5, 0, 9'h0, 2, 2));
    tbl.push_back(mk(0, 0, 0, ADD,  2,  7,  5, 1, ADD,  2, 2));
    tbl.push_back(mk(0, 0, 0, LDS,  1,  8,  0, 1, LDS,  2, 2));
    tbl.push_back(mk(0, 0, 0, ADI,  1,  8,  0, 1, ADI,  2, 2));
    tbl.push_back(mk(0, 0, 0, LDS,  1, 10,  0, 1, LDS,  2, 2));
    tbl.push_back(mk(0, 0, 0, LDS, 10, 11,  0, 0, 9'h0, 3, 3));
    tbl.push_back(mk(0, 0, 0, LDS, 10, 11,  0, 1, LDS,  3, 3));
    tbl.push_back(mk(0, 0, 0, ADD, 11, 11,  5, 0, 9'h0, 4, 3));
    tbl.push_back(mk(0, 0, 0, ADD, 11, 11,  5, 1, ADD,  4, 3));
    tbl.push_back(mk(0, 0, 0, LDS,  1, 12,  0, 1, LDS,  4, 3));
    tbl.push_back(mk(0, 0, 0, STW,  1, 12,  0, 0, 9'h0, 5, 3));
    tbl.push_back(mk(0, 0, 0, STW,  1, 12,  0, 1, STW,  5, 3));
    tbl.push_back(mk(0, 0, 0, NML,  1, 13,  0, 1, NML,  5, 3));
    tbl.push_back(mk(0, 0, 0, ADD, 13,  4,  5, 1, ADD,  5, 3));
    tbl.push_back(mk(0, 0, 0, LDS,  1, 14,  0, 1, LDS,  5, 3));
    tbl.push_back(mk(1, 0, 0, ADD, 14,  4,  5, 0, 9'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, ADD, 14,  4,  5, 1, ADD,  0, 0));

    // Reset with an all-ones control word on ID
    rst = 1'b1; flush = 1'b0; hold = 1'b0; ctrl_in = 9'h1FF;
    id_rs = 5'd3; id_rt = 5'd3; id_rd = 5'd3;
    id_rd1 = 16'hFFFF; id_rd2 = 16'hFFFF; id_imm = 16'hFFFF; id_pc1 = 16'hFFFF;
    @(posedge clk);
    #1;
    chk("rst_ex_ctrl", 64'(ex_ctrl), 64'(0));
    chk("rst_ex_rd1", 64'(ex_rd1), 64'(0));
    chk("rst_ex_rt", 64'(ex_rt), 64'(0));
    chk("rst_ex_pc1", 64'(ex_pc1), 64'(0));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    chk("rst_pc_write", 64'(pc_write), 64'(1));
    chk("rst_ifid_write", 64'(ifid_write), 64'(1));
    m = '0; m_cnt = 0; m_cnt2 = 0;

    foreach (tbl[i]) begin
      v = '0;
      v.rst = tbl[i].rst; v.flush = tbl[i].flush; v.hold = tbl[i].hold;
      v.ctrl = tbl[i].ctrl; v.rs = tbl[i].rs; v.rt = tbl[i].rt; v.rd = tbl[i].rd;
      v = rnd_data(v);
      cycle(v, pcw_mid);
      chk($sformatf("tbl%0d_pcw", i), 64'(pcw_mid), 64'(tbl[i].pcw));
      chk($sformatf("tbl%0d_ctrl", i), 64'(ex_ctrl), 64'(tbl[i].ex_ctrl));
      chk($sformatf("tbl%0d_cnt", i), 64'(stall_cnt), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_cnt2", i), 64'(stall_cnt2), 64'(tbl[i].cnt2));
    end

    // Randomized traffic with a small register pool so dependences are frequent
    for (int n = 0; n < 600; n++) begin
      v = '0;
      v.rst   = ($urandom_range(0, 79) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.hold  = ($urandom_range(0, 7) == 0);
      v.ctrl  = ($urandom_range(0, 2) == 0) ? (9'($urandom()) | 9'h020) : 9'($urandom());
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      v.rd    = 5'($urandom());
      v = rnd_data(v);
      cycle(v, pcw_mid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
